// File: rtl/laser_dac_servo.sv
// Laser-power servo that turns one per-frame intensity sample into a deadbanded,
// shift-gained DAC correction and sends it as WRUP + LDAC words to the SPI DAC master.
module laser_dac_servo #(
    parameter int ADC_W      = 12,
    parameter int DAC_W      = 16,
    parameter int TARGET     = 3500,
    parameter int DEADBAND   = 200,
    parameter int GAIN_SHIFT = 7,
    parameter int DAC_MIN    = 0,
    parameter int DAC_MAX    = 65490,
    parameter int DAC_INIT   = 20000,
    parameter int INVERT     = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               manual_mode,
    input  logic [DAC_W-1:0]   manual_code,
    input  logic [ADC_W-1:0]   sample,
    input  logic               sample_valid,
    input  logic               spi_busy,
    output logic               spi_start,
    output logic [8+DAC_W-1:0] spi_data,
    output logic [DAC_W-1:0]   dac_code,
    output logic               ready,
    output logic               update_done,
    output logic               sat_hi,
    output logic               sat_lo,
    output logic               overrun
);
    localparam int SPI_W = 8 + DAC_W;
    localparam int ERR_W = ADC_W + 2;
    localparam int SUM_W = DAC_W + 2;

    localparam logic [7:0]              CMD_CLR    = 8'h01;
    localparam logic [7:0]              CMD_WRUP   = 8'h10;
    localparam logic [7:0]              CMD_LDAC   = 8'h18;
    localparam logic [DAC_W-1:0]        INIT_CODE  = DAC_W'(DAC_INIT);
    localparam logic [DAC_W-1:0]        MIN_CODE   = DAC_W'(DAC_MIN);
    localparam logic [DAC_W-1:0]        MAX_CODE   = DAC_W'(DAC_MAX);
    localparam logic [DAC_W-1:0]        LDAC_ARG   = DAC_W'(1);
    localparam logic [ADC_W-1:0]        FULL_SCALE = '1;
    localparam logic signed [ERR_W-1:0] TARGET_S   = ERR_W'(TARGET);
    localparam logic signed [ERR_W-1:0] DB_S       = ERR_W'(DEADBAND);
    localparam logic signed [SUM_W-1:0] MIN_S      = SUM_W'(DAC_MIN);
    localparam logic signed [SUM_W-1:0] MAX_S      = SUM_W'(DAC_MAX);

    typedef enum logic [3:0] {
        INIT_CLR, W_CLR, INIT_WR, W_INIT_WR, INIT_LD, W_INIT_LD,
        READY, CALC, SEND_WR, W_WR, SEND_LD, W_LD
    } state_t;

    state_t             state, next_state;
    logic [ADC_W-1:0]   x_q;
    logic [DAC_W-1:0]   man_q, pend_q, dac_q;
    logic               mode_q;
    logic [SPI_W-1:0]   data_q, cmd_word;
    logic               is_send, take_sample;

    logic signed [ERR_W-1:0] err, step;
    logic signed [SUM_W-1:0] new_code;
    logic                    in_band, clamp_hi, clamp_lo, skip;
    logic [DAC_W-1:0]        clamped;

    assign take_sample = sample_valid & enable;

    // Correction datapath, evaluated while in CALC.
    assign err      = TARGET_S - $signed({2'b00, x_q});
    assign step     = err >>> GAIN_SHIFT;
    assign in_band  = (err <= DB_S) && (err >= -DB_S);
    assign new_code = mode_q ? $signed({2'b00, man_q})
                             : $signed({2'b00, dac_q}) + SUM_W'(step);
    assign clamp_hi = new_code > MAX_S;
    assign clamp_lo = new_code < MIN_S;
    assign clamped  = clamp_hi ? MAX_CODE : clamp_lo ? MIN_CODE : new_code[DAC_W-1:0];
    assign skip     = mode_q ? (clamped == dac_q) : in_band;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= INIT_CLR;
            x_q     <= '0;
            man_q   <= '0;
            mode_q  <= 1'b0;
            pend_q  <= '0;
            dac_q   <= INIT_CODE;
            data_q  <= '0;
            sat_hi  <= 1'b0;
            sat_lo  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state <= next_state;
            if (spi_start)
                data_q <= cmd_word;
            if (state == READY && take_sample) begin
                x_q    <= (INVERT != 0) ? FULL_SCALE - sample : sample;
                man_q  <= manual_code;
                mode_q <= manual_mode;
            end
            if (state != READY && take_sample)
                overrun <= 1'b1;
            if (state == CALC) begin
                // A deadband skip computes no code, so it cannot be saturated.
                sat_hi <= clamp_hi & (mode_q | ~in_band);
                sat_lo <= clamp_lo & (mode_q | ~in_band);
                pend_q <= clamped;
            end
            if (state == W_LD && !spi_busy)
                dac_q <= pend_q;
            if (state == W_INIT_LD && !spi_busy)
                dac_q <= INIT_CODE;
        end
    end

    // NOTE: every branch assigns next_state, and the default first keeps this block latch-free.
    always_comb begin
        next_state = state;
        case (state)
            INIT_CLR:  next_state = W_CLR;
            W_CLR:     if (!spi_busy) next_state = INIT_WR;
            INIT_WR:   next_state = W_INIT_WR;
            W_INIT_WR: if (!spi_busy) next_state = INIT_LD;
            INIT_LD:   next_state = W_INIT_LD;
            W_INIT_LD: if (!spi_busy) next_state = READY;
            READY:     if (take_sample) next_state = CALC;
            CALC:      next_state = skip ? READY : SEND_WR;
            SEND_WR:   next_state = W_WR;
            W_WR:      if (!spi_busy) next_state = SEND_LD;
            SEND_LD:   next_state = W_LD;
            W_LD:      if (!spi_busy) next_state = READY;
            default:   next_state = INIT_CLR;
        endcase
    end

    always_comb begin
        is_send  = 1'b0;
        cmd_word = data_q;
        case (state)
            INIT_CLR: begin is_send = 1'b1; cmd_word = {CMD_CLR, {DAC_W{1'b0}}}; end
            INIT_WR:  begin is_send = 1'b1; cmd_word = {CMD_WRUP, INIT_CODE}; end
            SEND_WR:  begin is_send = 1'b1; cmd_word = {CMD_WRUP, pend_q}; end
            INIT_LD,
            SEND_LD:  begin is_send = 1'b1; cmd_word = {CMD_LDAC, LDAC_ARG}; end
            default:  ;
        endcase
    end

    // Handshake outputs are gated by rst so an abort silences the SPI request at once.
    assign spi_start   = is_send & ~rst;
    assign spi_data    = spi_start ? cmd_word : data_q;
    assign update_done = (state == W_LD) & ~spi_busy & ~rst;
    assign ready       = (state == READY);
    assign dac_code    = dac_q;
endmodule

// File: tb/tb_laser_dac_servo.sv
// Directed self-checking bench for laser_dac_servo with a 16-cycle-busy SPI master model.
module tb_laser_dac_servo;
    logic        clk = 1'b0;
    logic        rst, enable, manual_mode, sample_valid, spi_busy;
    logic [15:0] manual_code;
    logic [11:0] sample;
    logic        spi_start, ready, update_done, sat_hi, sat_lo, overrun;
    logic [23:0] spi_data;
    logic [15:0] dac_code;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          busy_cnt = 0;
    int          upd_cnt = 0;
    int          upd_cyc = 0;
    int          t_cyc = 0;
    logic [23:0] words[$];
    int          start_cyc[$];

    laser_dac_servo dut (
        .clk(clk), .rst(rst), .enable(enable), .manual_mode(manual_mode),
        .manual_code(manual_code), .sample(sample), .sample_valid(sample_valid),
        .spi_busy(spi_busy), .spi_start(spi_start), .spi_data(spi_data),
        .dac_code(dac_code), .ready(ready), .update_done(update_done),
        .sat_hi(sat_hi), .sat_lo(sat_lo), .overrun(overrun)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SPI master model: logs each start, raises busy the next cycle for 16 cycles.
    initial begin
        logic        st;
        logic [23:0] d;
        spi_busy = 1'b0;
        forever begin
            @(negedge clk);
            st = spi_start;
            d  = spi_data;
            if (st) begin
                words.push_back(d);
                start_cyc.push_back(cyc);
            end
            if (update_done) begin
                upd_cnt++;
                upd_cyc = cyc;
            end
            @(posedge clk);
            #1;
            if (busy_cnt > 0) busy_cnt--;
            if (st) busy_cnt = 16;
            spi_busy = (busy_cnt > 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready_in_time"}, {31'd0, ready}, 32'd1);
    endtask

    // Drives a one-cycle sample strobe; returns during the following cycle (CALC when READY).
    task automatic pulse(input logic [11:0] s);
        @(posedge clk);
        #1;
        sample = s;
        sample_valid = 1'b1;
        t_cyc = cyc;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic clear_log();
        words.delete();
        start_cyc.delete();
        upd_cnt = 0;
    endtask

    initial begin
        int n;
        int rel_cyc;
        rst = 1'b1; enable = 1'b1; manual_mode = 1'b0; manual_code = '0;
        sample = '0; sample_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_spi_start", {31'd0, spi_start}, 32'd0);
        check("rst_spi_data", {8'd0, spi_data}, 32'd0);
        check("rst_dac_code", {16'd0, dac_code}, 32'd20000);
        check("rst_flags", {26'd0, ready, update_done, sat_hi, sat_lo, overrun, spi_start}, 32'd0);

        // Init sequence after release
        clear_log();
        @(posedge clk);
        #1;
        rst = 1'b0;
        rel_cyc = cyc;
        @(negedge clk);
        wait_ready("init");
        check("init_count", words.size(), 32'd3);
        if (words.size() == 3) begin
            check("init_clr", {8'd0, words[0]}, 32'h010000);
            check("init_wrup", {8'd0, words[1]}, 32'h104E20);
            check("init_ldac", {8'd0, words[2]}, 32'h180001);
            check("init_first_start_cyc", start_cyc[0], rel_cyc);
        end
        check("init_dac_code", {16'd0, dac_code}, 32'd20000);

        // Auto correction: x=3000, err=500, step=3
        clear_log();
        pulse(12'd1095);
        @(negedge clk);
        check("auto_calc_not_ready", {31'd0, ready}, 32'd0);
        @(negedge clk);
        check("auto_wrup_start_t2", {31'd0, spi_start}, 32'd1);
        check("auto_wrup_data_t2", {8'd0, spi_data}, 32'h104E23);
        wait_ready("auto");
        check("auto_count", words.size(), 32'd2);
        if (words.size() == 2) check("auto_ldac", {8'd0, words[1]}, 32'h180001);
        check("auto_dac_code", {16'd0, dac_code}, 32'd20003);
        check("auto_update_done_cnt", upd_cnt, 32'd1);
        check("auto_ready_after_done", cyc, upd_cyc + 1);

        // Inside deadband: x=3400, err=100
        clear_log();
        pulse(12'd695);
        @(negedge clk);
        check("db_calc_not_ready", {31'd0, ready}, 32'd0);
        @(negedge clk);
        check("db_ready_t2", {31'd0, ready}, 32'd1);
        repeat (5) @(negedge clk);
        check("db_no_start", words.size(), 32'd0);
        check("db_no_update", upd_cnt, 32'd0);
        check("db_dac_code", {16'd0, dac_code}, 32'd20003);

        // Manual code above DAC_MAX is clamped
        clear_log();
        manual_mode = 1'b1;
        manual_code = 16'd65535;
        pulse(12'd0);
        @(negedge clk);
        @(negedge clk);
        check("man_sat_hi", {31'd0, sat_hi}, 32'd1);
        wait_ready("man");
        check("man_count", words.size(), 32'd2);
        if (words.size() == 2) check("man_wrup", {8'd0, words[0]}, 32'h10FFD2);
        check("man_dac_code", {16'd0, dac_code}, 32'd65490);

        // Auto from the top: x=4095, err=-595, step=-5
        clear_log();
        manual_mode = 1'b0;
        pulse(12'd0);
        @(negedge clk);
        @(negedge clk);
        wait_ready("neg");
        check("neg_count", words.size(), 32'd2);
        if (words.size() == 2) check("neg_wrup", {8'd0, words[0]}, 32'h10FFCD);
        check("neg_dac_code", {16'd0, dac_code}, 32'd65485);
        check("neg_sat", {30'd0, sat_hi, sat_lo}, 32'd0);

        // Manual code equal to current code: no transaction
        clear_log();
        manual_mode = 1'b1;
        manual_code = 16'd65485;
        pulse(12'd0);
        @(negedge clk);
        @(negedge clk);
        check("man_eq_ready_t2", {31'd0, ready}, 32'd1);
        repeat (4) @(negedge clk);
        check("man_eq_no_start", words.size(), 32'd0);
        manual_mode = 1'b0;

        // Sample during W_WR sets sticky overrun and is dropped
        clear_log();
        check("ovr_clear_before", {31'd0, overrun}, 32'd0);
        pulse(12'd1095);
        @(negedge clk);
        @(negedge clk);
        repeat (3) @(negedge clk);
        pulse(12'd0);
        @(negedge clk);
        check("ovr_set", {31'd0, overrun}, 32'd1);
        wait_ready("ovr");
        repeat (6) @(negedge clk);
        check("ovr_one_pair", words.size(), 32'd2);
        if (words.size() == 2) check("ovr_wrup", {8'd0, words[0]}, 32'h10FFD0);
        check("ovr_dac_code", {16'd0, dac_code}, 32'd65488);

        // enable=0 in READY: ignored, overrun stays set
        clear_log();
        enable = 1'b0;
        pulse(12'd0);
        repeat (4) @(negedge clk);
        check("dis_no_start", words.size(), 32'd0);
        check("dis_ready", {31'd0, ready}, 32'd1);
        check("ovr_sticky", {31'd0, overrun}, 32'd1);
        enable = 1'b1;

        // Reset while W_LD is waiting on busy
        clear_log();
        pulse(12'd1095);
        @(negedge clk);
        @(negedge clk);
        check("abort_sat_hi", {31'd0, sat_hi}, 32'd1);
        n = 0;
        while (words.size() < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("abort_ldac_issued", words.size(), 32'd2);
        repeat (3) @(negedge clk);
        check("abort_in_wld", {30'd0, ready, spi_busy}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("abort_spi_start", {31'd0, spi_start}, 32'd0);
        @(negedge clk);
        check("abort_dac_code", {16'd0, dac_code}, 32'd20000);
        check("abort_overrun", {31'd0, overrun}, 32'd0);
        check("abort_sat", {30'd0, sat_hi, sat_lo}, 32'd0);
        clear_log();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        wait_ready("reinit");
        check("reinit_count", words.size(), 32'd3);
        if (words.size() == 3) begin
            check("reinit_clr", {8'd0, words[0]}, 32'h010000);
            check("reinit_wrup", {8'd0, words[1]}, 32'h104E20);
            check("reinit_ldac", {8'd0, words[2]}, 32'h180001);
        end
        check("reinit_dac_code", {16'd0, dac_code}, 32'd20000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end
endmodule
